// File: rtl/spi_slave_nbit.sv
// SPI slave for any CPOL/CPHA: decodes R/W + address + data frames into
// single-clk register write/read strobes on the system clock.
module spi_slave_nbit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 7,
  parameter bit          CPOL   = 1'b0,
  parameter bit          CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              cs_i,
  input  logic              sdi_i,
  output logic              sdo_o,
  output logic              sdo_oe_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              wr_o,
  output logic              rd_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o,
  output logic              abort_o
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RLOAD, RDATA, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        scl_sync, cs_sync;
  logic [1:0]        sdi_sync;
  logic              scl_s, scl_d, cs_s, cs_d, sdi_s;
  logic              lead_edge, trail_edge, sample_edge, shift_edge, cs_rise, cs_fall;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              addr_last, data_last;
  logic              rw, rw_nx, load_wait, load_wait_nx, wr_pend, wr_pend_nx, seen, seen_nx;
  logic [ADDR_W-1:0] addr_sr, addr_sr_nx, addr_shift, addr_nx;
  logic [DATA_W-1:0] data_sr, data_sr_nx, data_shift, tx_sr, tx_nx, wdata_nx;
  logic              sdo_nx, oe_nx, wr_nx, rd_nx, busy_nx, abort_nx;

  // Synchronizers are left out of reset so a cs already high at reset release
  // is never mistaken for a fresh cs rising edge.
  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[1:0], scl_i};
    cs_sync  <= {cs_sync[1:0], cs_i};
    sdi_sync <= {sdi_sync[0], sdi_i};
  end

  assign scl_s       = scl_sync[1];
  assign scl_d       = scl_sync[2];
  assign cs_s        = cs_sync[1];
  assign cs_d        = cs_sync[2];
  assign sdi_s       = sdi_sync[1];
  assign lead_edge   = (scl_d == CPOL) && (scl_s != CPOL);
  assign trail_edge  = (scl_d != CPOL) && (scl_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_rise     = cs_s && !cs_d;
  assign cs_fall     = !cs_s && cs_d;
  assign addr_last   = (cnt == CNT_W'(ADDR_W - 1));
  assign data_last   = (cnt == CNT_W'(DATA_W - 1));
  assign addr_shift  = ADDR_W'({addr_sr, sdi_s});
  assign data_shift  = DATA_W'({data_sr, sdi_s});

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rw_nx        = rw;
    load_wait_nx = load_wait;
    wr_pend_nx   = wr_pend;
    seen_nx      = seen;
    addr_sr_nx   = addr_sr;
    data_sr_nx   = data_sr;
    tx_nx        = tx_sr;
    addr_nx      = addr_o;
    wdata_nx     = wdata_o;
    oe_nx        = sdo_oe_o;
    wr_nx        = 1'b0;
    rd_nx        = 1'b0;
    abort_nx     = 1'b0;

    unique case (state)
      IDLE: begin
        if (cs_rise) begin
          state_nx = CMD;
          cnt_nx   = '0;
        end
      end
      CMD: begin
        if (sample_edge) begin
          rw_nx    = sdi_s;
          cnt_nx   = '0;
          state_nx = ADDR;
        end
      end
      ADDR: begin
        if (sample_edge) begin
          addr_sr_nx = addr_shift;
          cnt_nx     = cnt + CNT_W'(1);
          if (addr_last) begin
            addr_nx = addr_shift;
            cnt_nx  = '0;
            if (rw) begin
              state_nx     = RLOAD;
              rd_nx        = 1'b1;
              load_wait_nx = 1'b1;
            end else begin
              state_nx = WDATA;
            end
          end
        end
      end
      WDATA: begin
        if (wr_pend) begin
          wr_nx      = 1'b1;
          wr_pend_nx = 1'b0;
          state_nx   = DONE;
        end else if (sample_edge) begin
          data_sr_nx = data_shift;
          cnt_nx     = cnt + CNT_W'(1);
          if (data_last) begin
            wdata_nx   = data_shift;
            wr_pend_nx = 1'b1;
          end
        end
      end
      RLOAD: begin
        // First cycle: rd_o is out; rdata_i is valid on the next one.
        if (load_wait) begin
          load_wait_nx = 1'b0;
        end else begin
          tx_nx    = rdata_i;
          oe_nx    = 1'b1;
          seen_nx  = 1'b0;
          state_nx = RDATA;
        end
      end
      RDATA: begin
        if (sample_edge) begin
          seen_nx = 1'b1;
          cnt_nx  = cnt + CNT_W'(1);
          if (data_last) begin
            oe_nx    = 1'b0;
            state_nx = DONE;
          end
        end else if (shift_edge && seen) begin
          tx_nx = DATA_W'({tx_sr, 1'b0});
        end
      end
      DONE: begin
        if (cs_fall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Incomplete frame: drop everything and flag it
    if (cs_fall && (state != IDLE) && (state != DONE)) begin
      state_nx     = IDLE;
      abort_nx     = 1'b1;
      wr_nx        = 1'b0;
      rd_nx        = 1'b0;
      oe_nx        = 1'b0;
      wr_pend_nx   = 1'b0;
      load_wait_nx = 1'b0;
    end

    sdo_nx  = (state_nx == RDATA) ? tx_nx[DATA_W-1] : 1'b0;
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rw        <= 1'b0;
      load_wait <= 1'b0;
      wr_pend   <= 1'b0;
      seen      <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      tx_sr     <= '0;
      addr_o    <= '0;
      wdata_o   <= '0;
      sdo_o     <= 1'b0;
      sdo_oe_o  <= 1'b0;
      wr_o      <= 1'b0;
      rd_o      <= 1'b0;
      busy_o    <= 1'b0;
      abort_o   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rw        <= rw_nx;
      load_wait <= load_wait_nx;
      wr_pend   <= wr_pend_nx;
      seen      <= seen_nx;
      addr_sr   <= addr_sr_nx;
      data_sr   <= data_sr_nx;
      tx_sr     <= tx_nx;
      addr_o    <= addr_nx;
      wdata_o   <= wdata_nx;
      sdo_o     <= sdo_nx;
      sdo_oe_o  <= oe_nx;
      wr_o      <= wr_nx;
      rd_o      <= rd_nx;
      busy_o    <= busy_nx;
      abort_o   <= abort_nx;
    end
  end

endmodule
